// File: rtl/rv32_mem_pkg.sv
// rtl/rv32_mem_pkg.sv - shared RV32I memory width codes and responder FSM states
package rv32_mem_pkg;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

endpackage

// File: rtl/load_formatter.sv
// rtl/load_formatter.sv - RV32I load lane select with sign/zero extension
// err also flags illegal width codes and misalignment, so stores reuse it.
module load_formatter
   import rv32_mem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  funct3,
   output logic [31:0] rdata,
   output logic        err
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = 8'(word >> {addr_lo, 3'b000});
      half_sel = addr_lo[1] ? word[31:16] : word[15:0];
      rdata    = '0;
      err      = 1'b0;
      case (funct3)
         F3_B:  rdata = {{24{byte_sel[7]}}, byte_sel};
         F3_BU: rdata = {24'h0, byte_sel};
         F3_H, F3_HU: begin
            if (addr_lo[0]) begin
               err = 1'b1;
            end else if (funct3 == F3_H) begin
               rdata = {{16{half_sel[15]}}, half_sel};
            end else begin
               rdata = {16'h0, half_sel};
            end
         end
         F3_W: begin
            if (addr_lo != 2'b00) begin
               err = 1'b1;
            end else begin
               rdata = word;
            end
         end
         default: err = 1'b1;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency data-memory responder for the rv32i MEM stage
module dmem_responder
   import rv32_mem_pkg::*;
#(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        dmem_valid,
   output logic [31:0] rdata,
   output logic        err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          we_q, we_d;
   logic [2:0]    f3_q, f3_d;
   logic [AW+1:0] addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          valid_q, valid_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          err_q, err_d;

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] idx;
   logic [31:0]   fmt_rdata;
   logic          fmt_err;
   logic          acc_err;
   logic          do_access;
   logic          do_write;
   logic [3:0]    be;
   logic [31:0]   wlane;
   logic          unused_addr_hi;

   // Bits above the array span are deliberately dropped: addresses wrap.
   assign unused_addr_hi = ^req_addr[31:AW+2];

   assign idx       = addr_q[AW+1:2];
   assign acc_err   = fmt_err | (we_q & ((f3_q == F3_BU) | (f3_q == F3_HU)));
   assign do_access = (state_q == ST_WAIT) && (cnt_q == '0);
   assign do_write  = do_access && we_q && !acc_err;

   load_formatter u_fmt (
      .word    (mem[idx]),
      .addr_lo (addr_q[1:0]),
      .funct3  (f3_q),
      .rdata   (fmt_rdata),
      .err     (fmt_err)
   );

   always_comb begin
      be    = 4'hF;
      wlane = wdata_q;
      case (f3_q[1:0])
         2'd0: begin
            be    = 4'b0001 << addr_q[1:0];
            wlane = {4{wdata_q[7:0]}};
         end
         2'd1: begin
            be    = addr_q[1] ? 4'b1100 : 4'b0011;
            wlane = {2{wdata_q[15:0]}};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (do_write) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      f3_d    = f3_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      valid_d = 1'b0;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               f3_d    = req_funct3;
               addr_d  = req_addr[AW+1:0];
               wdata_d = req_wdata;
               cnt_d   = CNT_INIT;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               valid_d = 1'b1;
               rdata_d = (acc_err || we_q) ? 32'h0 : fmt_rdata;
               err_d   = acc_err;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         f3_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         valid_q <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         f3_q    <= f3_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         valid_q <= valid_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign req_ready  = (state_q == ST_IDLE);
   assign dmem_valid = valid_q;
   assign rdata      = rdata_q;
   assign err        = err_q;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder for the rv32i pipeline. It serves the load/store requests that hold the PC stalled on `load && !dmem_valid`.
- Accepts one request at a time and performs the access after a fixed latency on an internal word array.
- Pulses dmem_valid for exactly one cycle with the RV32I byte/half/word-formatted result.
- Sits between the MEM stage and local data RAM. It is the far end of the dmem_valid handshake.

Parameters:
- DEPTH, 1024, number of 32-bit words in the array (power of two)
- LATENCY, 2, cycles from request acceptance to dmem_valid (integer, >= 1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present; requester holds all req_* stable until dmem_valid
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width code: 0 lb/sb, 1 lh/sh, 2 lw/sw, 4 lbu, 5 lhu
- req_addr  in  32  byte address
- req_wdata  in  32  store data, LSB-aligned
- req_ready  out  1  high in IDLE only
- dmem_valid  out  1  one-cycle completion pulse, for loads and stores
- rdata  out  32  formatted load data, valid with dmem_valid
- err  out  1  misaligned or illegal funct3, valid with dmem_valid

Behaviour:
- Reset (rst low, async):
  - state=IDLE, counter=0.
  - dmem_valid=0, rdata=0, err=0, captured request regs=0.
  - Array contents are not reset.
  - Reset mid-operation aborts the access; no array write occurs.
- FSM states IDLE, WAIT, RESP:
  - IDLE: req_ready=1. On an edge with req_valid=1, capture we/funct3/addr/wdata, counter<=LATENCY-1, go to WAIT.
  - WAIT: if counter==0, perform the access, dmem_valid<=1, go to RESP; else counter<=counter-1.
  - RESP: dmem_valid<=0, go to IDLE. req_valid is ignored in WAIT and RESP.
- Timing:
  - A request sampled at edge E0 gives dmem_valid high in the cycle after edge E0+LATENCY.
  - The earliest next acceptance is edge E0+LATENCY+2.
- Word index = addr[log2(DEPTH)+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*DEPTH bytes.
- Loads (lane chosen by addr[1:0]):
  - lb sign-extends the selected byte; lbu zero-extends it.
  - lh/lhu use the half-word selected by addr[1], sign- or zero-extended.
  - lw returns the full word.
- Stores:
  - sb writes byte lane addr[1:0] with wdata[7:0].
  - sh writes lanes {addr[1],0..1} with wdata[15:0].
  - sw writes all four lanes. Other lanes are untouched.
- Error conditions: half access with addr[0]=1, word access with addr[1:0]!=0, or funct3 in {3,6,7} (also funct3 4/5 with we=1).
  - On error: no write, rdata=0, err=1, dmem_valid still pulses.
- rdata/err hold their value after the pulse until the next completion.
- A store followed by a load to the same address returns the new data.

Decomposition:
- Shared package `rv32_mem_pkg`: funct3 width localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU) and FSM state encoding.
- One sub-module, `load_formatter`: combinational lane select plus sign/zero extension (word, addr[1:0], funct3 -> rdata, err).
- Store byte-enable generation stays inline.

Test Plan:
- Reset then sw addr=0x10 wdata=0xDEADBEEF, LATENCY=2 -> req_ready drops the next cycle; dmem_valid high exactly one cycle, 2 edges after acceptance; err=0.
- lw 0x10, lb 0x13, lbu 0x13, lh 0x12, lhu 0x12 -> 0xDEADBEEF, 0xFFFFFFDE, 0x000000DE, 0xFFFFDEAD, 0x0000DEAD.
- sb 0x11 wdata=0x55, then lw 0x10 -> 0xDEAD55EF.
- lw 0x12 and sh 0x11 -> err=1, rdata=0, dmem_valid pulses; a later lw 0x10 shows the word unchanged.
- sw addr=0x10+4*DEPTH wdata=0x12345678 -> lw 0x10 returns 0x12345678 (wrap).
- Assert rst during WAIT of sw 0x20 wdata=0x1 -> dmem_valid never pulses, state IDLE; a following lw 0x20 returns the prior contents.
